// File: rtl/arraymul_pkg.sv
// Shared types and helpers for the matrix loader: state encoding, default
// sizes, and the column-major to row-major slice remap.
package arraymul_pkg;

    localparam int DIM_DEF    = 3;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } loader_state_t;

    // The j-th column-major element sits at (row = j mod dim, col = j div dim).
    function automatic int col_to_row(input int j, input int dim);
        return (j % dim) * dim + (j / dim);
    endfunction

endpackage

// File: rtl/loader_counter.sv
// Element counter for the matrix loader: synchronous clear, increment,
// and a terminal-count flag. It saturates at the terminal count.
module loader_counter #(
    parameter int LIMIT = 18,
    parameter int CW    = $clog2(LIMIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Streams 2*DIM*DIM elements into matrices A then B and holds them for a consumer.
//   state   | meaning
//   IDLE    | waiting for start, matrices retained
//   LOAD    | accepting elements, A first then B
//   FULL    | both matrices complete, input refused
module matrix_loader
    import arraymul_pkg::*;
#(
    parameter int DIM         = DIM_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int B_COL_MAJOR = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    release_req,   // "release" is a reserved word
    output logic                    done,
    output logic                    overrun,
    output logic [DIM*DIM*DATA_W-1:0] mat_a,
    output logic [DIM*DIM*DATA_W-1:0] mat_b
);

    localparam int NE = DIM * DIM;
    localparam int CW = $clog2(2 * NE);
    localparam int IW = $clog2(NE);

    loader_state_t state, state_next;

    logic [CW-1:0]     count;
    logic              tc;
    logic              xfer;
    logic              in_b;
    logic [CW-1:0]     b_off;
    logic [IW-1:0]     a_idx;
    logic [IW-1:0]     b_idx;
    logic [DATA_W-1:0] a_mem [NE];
    logic [DATA_W-1:0] b_mem [NE];

    loader_counter #(
        .LIMIT (2 * NE),
        .CW    (CW)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (xfer),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start seen in LOAD restarts the load, so the element on that edge is dropped.
    always_comb begin
        state_next = state;
        data_ready = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                data_ready = 1'b1;
                xfer       = data_valid && !start;
                if (xfer && tc) state_next = ST_FULL;
            end
            ST_FULL: begin
                done = 1'b1;
                if (start)            state_next = ST_LOAD;
                else if (release_req) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_b  = (count >= CW'(NE));
    assign b_off = count - CW'(NE);
    assign a_idx = count[IW-1:0];

    always_comb begin
        b_idx = b_off[IW-1:0];
        if (B_COL_MAJOR != 0) begin
            b_idx = IW'(col_to_row(int'(b_off), DIM));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (xfer) begin
            if (in_b) begin
                b_mem[b_idx] <= data_in;
            end else begin
                a_mem[a_idx] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            overrun <= 1'b0;
        end else if (state == ST_FULL && data_valid) begin
            overrun <= 1'b1;
        end
    end

    for (genvar g = 0; g < NE; g++) begin : g_pack
        assign mat_a[g*DATA_W +: DATA_W] = a_mem[g];
        assign mat_b[g*DATA_W +: DATA_W] = b_mem[g];
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: three instances (3x3 row-major B, 3x3 column-major B,
// 4x4 with 12-bit data) share control, checked against a behavioural model.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        data_valid = 1'b0;
    logic        release_req = 1'b0;
    logic [15:0] din = '0;

    logic         r3_ready, r3_done, r3_ovr;
    logic [71:0]  r3_a, r3_b;
    logic         c3_ready, c3_done, c3_ovr;
    logic [71:0]  c3_a, c3_b;
    logic         q4_ready, q4_done, q4_ovr;
    logic [191:0] q4_a, q4_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    matrix_loader #(.DIM(3), .DATA_W(8), .B_COL_MAJOR(0)) u_r3 (
        .clk(clk), .reset(reset), .start(start), .data_in(din[7:0]),
        .data_valid(data_valid), .data_ready(r3_ready), .release_req(release_req),
        .done(r3_done), .overrun(r3_ovr), .mat_a(r3_a), .mat_b(r3_b));

    matrix_loader #(.DIM(3), .DATA_W(8), .B_COL_MAJOR(1)) u_c3 (
        .clk(clk), .reset(reset), .start(start), .data_in(din[7:0]),
        .data_valid(data_valid), .data_ready(c3_ready), .release_req(release_req),
        .done(c3_done), .overrun(c3_ovr), .mat_a(c3_a), .mat_b(c3_b));

    matrix_loader #(.DIM(4), .DATA_W(12), .B_COL_MAJOR(0)) u_q4 (
        .clk(clk), .reset(reset), .start(start), .data_in(din[11:0]),
        .data_valid(data_valid), .data_ready(q4_ready), .release_req(release_req),
        .done(q4_done), .overrun(q4_ovr), .mat_a(q4_a), .mat_b(q4_b));

    // Model: phase 0 idle, 1 loading, 2 full; B kept as (row,col) placements.
    int m_phase [2];
    int m_cnt   [2];
    int m_ovr   [2];
    int m_a     [2][64];
    int m_b     [2][64];
    int m_bc    [64];

    task automatic model_step(input int id, input int dim, input int dmask);
        int dd;
        int v;
        int j;
        dd = dim * dim;
        v  = int'(din) & dmask;
        if (reset) begin
            m_phase[id] = 0;
            m_cnt[id]   = 0;
            m_ovr[id]   = 0;
            for (int i = 0; i < 64; i++) begin
                m_a[id][i] = 0;
                m_b[id][i] = 0;
                if (id == 0) m_bc[i] = 0;
            end
        end else if (m_phase[id] == 0) begin
            if (start) begin
                m_phase[id] = 1;
                m_cnt[id]   = 0;
                m_ovr[id]   = 0;
            end
        end else if (m_phase[id] == 1) begin
            if (start) begin
                m_cnt[id] = 0;
            end else if (data_valid) begin
                if (m_cnt[id] < dd) begin
                    m_a[id][m_cnt[id]] = v;
                end else begin
                    j = m_cnt[id] - dd;
                    m_b[id][j] = v;
                    if (id == 0) m_bc[(j % dim) * dim + (j / dim)] = v;
                end
                m_cnt[id]++;
                if (m_cnt[id] == 2 * dd) m_phase[id] = 2;
            end
        end else begin
            if (start) begin
                m_phase[id] = 1;
                m_cnt[id]   = 0;
                m_ovr[id]   = 0;
            end else begin
                if (data_valid) m_ovr[id] = 1;
                if (release_req) m_phase[id] = 0;
            end
        end
    endtask

    function automatic logic [255:0] pack(input int id, input int which, input int dim, input int w);
        logic [255:0] r;
        int val;
        r = '0;
        for (int i = 0; i < dim * dim; i++) begin
            val = (which == 0) ? m_a[id][i] : (which == 1) ? m_b[id][i] : m_bc[i];
            r = r | (256'(val) << (i * w));
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 3, 'hFF);
        model_step(1, 4, 'hFFF);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("r3_ready", 256'(r3_ready), 256'(m_phase[0] == 1));
            cmp("r3_done",  256'(r3_done),  256'(m_phase[0] == 2));
            cmp("r3_ovr",   256'(r3_ovr),   256'(m_ovr[0]));
            cmp("r3_mat_a", 256'(r3_a),     pack(0, 0, 3, 8));
            cmp("r3_mat_b", 256'(r3_b),     pack(0, 1, 3, 8));
            cmp("c3_ready", 256'(c3_ready), 256'(m_phase[0] == 1));
            cmp("c3_done",  256'(c3_done),  256'(m_phase[0] == 2));
            cmp("c3_ovr",   256'(c3_ovr),   256'(m_ovr[0]));
            cmp("c3_mat_a", 256'(c3_a),     pack(0, 0, 3, 8));
            cmp("c3_mat_b", 256'(c3_b),     pack(0, 2, 3, 8));
            cmp("q4_ready", 256'(q4_ready), 256'(m_phase[1] == 1));
            cmp("q4_done",  256'(q4_done),  256'(m_phase[1] == 2));
            cmp("q4_ovr",   256'(q4_ovr),   256'(m_ovr[1]));
            cmp("q4_mat_a", 256'(q4_a),     pack(1, 0, 4, 12));
            cmp("q4_mat_b", 256'(q4_b),     pack(1, 1, 4, 12));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic stream(input int base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            din        = 16'(base + i);
            data_valid = 1'b1;
            cyc();
            if (gap) begin
                data_valid = 1'b0;
                cyc();
            end
        end
        data_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        cmp("rst_ready", 256'(r3_ready), 256'(0));
        cmp("rst_done",  256'(r3_done),  256'(0));
        cmp("rst_ovr",   256'(r3_ovr),   256'(0));
        cmp("rst_mat_a", 256'(r3_a),     256'(0));

        // Continuous stream 1..18
        pulse_start();
        stream(1, 17, 1'b0);
        cmp("done_before_last", 256'(r3_done), 256'(0));
        stream(18, 1, 1'b0);
        cmp("cont_done",  256'(r3_done), 256'(1));
        cmp("cont_mat_a", 256'(r3_a), 256'(72'h09_08_07_06_05_04_03_02_01));
        cmp("cont_mat_b", 256'(r3_b), 256'(72'h12_11_10_0f_0e_0d_0c_0b_0a));
        cmp("colmaj_b",   256'(c3_b), 256'(72'h12_0f_0c_11_0e_0b_10_0d_0a));

        // Same stream with a bubble after every element
        do_reset();
        pulse_start();
        stream(1, 18, 1'b1);
        cmp("gap_done",  256'(r3_done), 256'(1));
        cmp("gap_mat_a", 256'(r3_a), 256'(72'h09_08_07_06_05_04_03_02_01));
        cmp("gap_mat_b", 256'(r3_b), 256'(72'h12_11_10_0f_0e_0d_0c_0b_0a));

        // Overrun while FULL, release, then start clears it
        din = 16'h00FF;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        cmp("ovr_set",   256'(r3_ovr), 256'(1));
        cmp("ovr_mat_a", 256'(r3_a), 256'(72'h09_08_07_06_05_04_03_02_01));
        release_req = 1'b1;
        cyc();
        release_req = 1'b0;
        cmp("rel_done", 256'(r3_done), 256'(0));
        cmp("rel_ovr_sticky", 256'(r3_ovr), 256'(1));
        pulse_start();
        cmp("start_clr_ovr", 256'(r3_ovr), 256'(0));

        // Restart after 5 transfers; element on the restart edge is dropped
        stream(16'h40, 5, 1'b0);
        din = 16'h0077;
        data_valid = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        data_valid = 1'b0;
        cmp("restart_keep", 256'(r3_a[7:0]), 256'(8'h40));
        stream(16'h21, 18, 1'b0);
        cmp("restart_s0",   256'(r3_a[7:0]),   256'(8'h21));
        cmp("restart_s4",   256'(r3_a[39:32]), 256'(8'h25));
        cmp("restart_done", 256'(r3_done), 256'(1));

        // Reset mid-load, then data without a start is refused
        do_reset();
        pulse_start();
        stream(16'h50, 10, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cmp("midrst_a",     256'(r3_a), 256'(0));
        cmp("midrst_b",     256'(r3_b), 256'(0));
        cmp("midrst_ready", 256'(r3_ready), 256'(0));
        stream(16'h60, 3, 1'b0);
        cmp("nostart_a", 256'(r3_a), 256'(0));

        // 4x4 with 12-bit elements
        pulse_start();
        stream(1, 31, 1'b0);
        cmp("q4_done_31", 256'(q4_done), 256'(0));
        stream(32, 1, 1'b0);
        cmp("q4_done_32", 256'(q4_done), 256'(1));
        cmp("q4_b15",     256'(q4_b[191:180]), 256'(12'h020));
        cmp("q4_a0",      256'(q4_a[11:0]), 256'(12'h001));

        // Start has priority over a simultaneous release
        start = 1'b1;
        release_req = 1'b1;
        cyc();
        start = 1'b0;
        release_req = 1'b0;
        cmp("prio_ready", 256'(q4_ready), 256'(1));
        cmp("prio_done",  256'(q4_done), 256'(0));
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter DIM, default 3, matrix dimension; legal range 2..8.
REQ-002 Parameter DATA_W, default 8, element width in bits; legal range 4..16.
REQ-003 Parameter B_COL_MAJOR, default 0; when 1, B elements arrive column-major and SHALL be stored row-major.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; arms a new load from IDLE or FULL.
REQ-007 data_in  input  DATA_W  streamed element.
REQ-008 data_valid  input  1  data_in valid this cycle.
REQ-009 data_ready  output  1  loader accepts an element this cycle.
REQ-010 release  input  1  consumer finished with matrices; returns FULL to IDLE.
REQ-011 done  output  1  high while both matrices are complete (state FULL).
REQ-012 overrun  output  1  sticky; valid data offered while FULL.
REQ-013 mat_a  output  DIM*DIM*DATA_W  A row-major; element (r,c) at slice index r*DIM+c, index 0 in LSBs.
REQ-014 mat_b  output  DIM*DIM*DATA_W  B, same packing as mat_a.

Function
REQ-015 States: IDLE, LOAD, FULL.
REQ-016 IDLE: data_ready=0, done=0; start -> LOAD with element counter cleared to 0.
REQ-017 LOAD: data_ready=1; transfer occurs when data_valid && data_ready on a rising edge.
REQ-018 Transfer k (0..DIM*DIM-1) SHALL write A slice k; transfer DIM*DIM+j SHALL write B slice j (B_COL_MAJOR=0) or slice (j mod DIM)*DIM + (j div DIM) (B_COL_MAJOR=1).
REQ-019 Counter width SHALL be clog2(2*DIM*DIM); no wrap during LOAD.
REQ-020 Final transfer (count 2*DIM*DIM-1) SHALL move LOAD -> FULL; done rises the cycle after that edge; zero-cycle bubbles in valid permitted.
REQ-021 data_valid low in LOAD: no write, counter holds, no timeout.
REQ-022 FULL: data_ready=0, mat_a/mat_b held; data_valid=1 sets overrun; data discarded.
REQ-023 FULL with release=1 -> IDLE; matrices retained until overwritten.
REQ-024 start in FULL -> LOAD directly, counter cleared, overrun cleared; start takes priority over simultaneous release.
REQ-025 start in LOAD SHALL restart: counter cleared, element on same edge is not written, previously written slices retain old values until overwritten.
REQ-026 start in IDLE clears overrun.
REQ-027 release outside FULL ignored.

Reset
REQ-028 reset asserted at a clock edge SHALL force state IDLE, counter 0, done 0, overrun 0, mat_a and mat_b all zero; reset overrides start, release, data_valid.
REQ-029 reset mid-LOAD discards partial load; first post-reset transfer requires a new start.

Structure
REQ-030 Package arraymul_pkg SHALL hold state enum loader_state_t and default constants DIM_DEF=3, DATA_W_DEF=8.
REQ-031 Column-major index remap SHALL be a function in arraymul_pkg.
REQ-032 One sub-module, loader_counter (clear, increment, terminal-count flag), instantiated once.

Verification
REQ-033 DIM=3, DATA_W=8: reset, start, stream 1..18 continuous -> mat_a slices 0..8 = 1..9, mat_b = 10..18, done high after 18th transfer.
REQ-034 Same stream with valid toggling every other cycle -> identical final contents; counter holds during gaps.
REQ-035 B_COL_MAJOR=1, B stream 10..18 -> mat_b slices = 10,13,16,11,14,17,12,15,18.
REQ-036 FULL, offer data_valid with 8'hFF -> overrun=1, contents unchanged; release -> IDLE, done=0; start -> overrun=0.
REQ-037 start after 5 transfers -> next 18 transfers load from slice 0; reset after 10 transfers -> all outputs zero, data_ready=0.
REQ-038 DIM=4, DATA_W=12: 32 transfers 12'h001..12'h020 -> done after 32nd, mat_b slice 15 = 12'h020.
